// File: rtl/drum_pkg.sv
// Shared types and constants for the drum voice sample path.
package drum_pkg;

    localparam int SAMPLE_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } streamer_state_t;

endpackage

// File: rtl/drum_sample_streamer.sv
// Streams one drum hit from an external synchronous sample ROM into the codec
// write FIFO, one sample per FETCH/HOLD round trip. Restartable while busy.
module drum_sample_streamer
    import drum_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int SAMPLE_LEN = 12000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                trigger,
    input  logic                enable,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_data,
    input  logic                write_ready,
    output logic                write,
    output logic [SAMPLE_W-1:0] sample,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLE_LEN - 1);

    streamer_state_t       state_q, state_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    // Set once the ROM word for idx_q has been latched; write is held off until then.
    logic                  cap_q, cap_d;
    logic                  done_q, done_d;

    // State register; reset aborts any hit without a done pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sample_q <= '0;
            cap_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            cap_q    <= cap_d;
            done_q   <= done_d;
        end
    end

    // Next-state and transfer strobe. Priority while busy:
    // enable low (abort) > retrigger > ROM capture > transfer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        cap_d    = cap_q;
        done_d   = 1'b0;
        write    = 1'b0;
        case (state_q)
            IDLE: begin
                cap_d = 1'b0;
                if (trigger && enable) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cap_d = 1'b0;
                if (!enable) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (trigger) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!enable) begin
                    idx_d   = '0;
                    cap_d   = 1'b0;
                    state_d = IDLE;
                end else if (trigger) begin
                    // Pending sample is dropped; no write this cycle.
                    idx_d   = '0;
                    cap_d   = 1'b0;
                    state_d = FETCH;
                end else if (!cap_q) begin
                    // ROM word for idx_q is valid during this first HOLD cycle.
                    sample_d = rom_data;
                    cap_d    = 1'b1;
                end else if (write_ready) begin
                    write = 1'b1;
                    cap_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                cap_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Address is held through HOLD so the ROM output stays stable while waiting.
    assign rom_addr = (state_q == IDLE) ? '0 : idx_q;
    assign sample   = (state_q == IDLE) ? '0 : sample_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_drum_sample_streamer.sv
// Scoreboard bench for drum_sample_streamer: SAMPLE_LEN=4, ROM word k -> 0x100*(k+1).
module tb_drum_sample_streamer;

    logic        CLOCK_50 = 1'b0;
    logic        reset, trigger, enable, write_ready;
    logic [13:0] rom_addr;
    logic [23:0] rom_data;
    logic        write, busy, done;
    logic [23:0] sample;

    int          total = 0;
    int          bad   = 0;
    int          done_seen = 0;
    int          done_exp  = 0;
    logic [23:0] exp_q[$];
    logic [13:0] alog[$];
    logic        pbusy = 1'b0;
    logic [13:0] paddr = '0;

    drum_sample_streamer #(.ADDR_W(14), .SAMPLE_LEN(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .trigger     (trigger),
        .enable      (enable),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .write_ready (write_ready),
        .write       (write),
        .sample      (sample),
        .busy        (busy),
        .done        (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [23:0] rom_word(input logic [13:0] a);
        return (24'(a) + 24'd1) << 8;
    endfunction

    // Synchronous ROM model, one cycle latency.
    always @(posedge CLOCK_50) rom_data <= rom_word(rom_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, counts done pulses, logs addresses.
    always @(negedge CLOCK_50) begin
        if (write === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_write", {8'h0, sample}, 32'hFFFF_FFFF);
            else chk("write_sample", {8'h0, sample}, {8'h0, exp_q.pop_front()});
        end
        if (done === 1'b1) done_seen++;
        if (busy && (!pbusy || rom_addr != paddr)) alog.push_back(rom_addr);
        pbusy = busy;
        paddr = rom_addr;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_hit(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(rom_word(14'(k)));
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 100 && busy; i++) cyc(1);
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; enable = 1'b1; write_ready = 1'b1;
        cyc(3);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_write", {31'd0, write}, 0);
        chk("rst_sample", {8'd0, sample}, 0);
        chk("rst_addr", {18'd0, rom_addr}, 0);
        chk("rst_done", {31'd0, done}, 0);
        reset = 1'b0;
        cyc(1);

        // Plain hit with ready always high.
        alog.delete();
        push_hit(4); done_exp++;
        trigger = 1'b1; cyc(1); trigger = 1'b0;
        chk("s1_first_addr", {18'd0, rom_addr}, 0);
        chk("s1_busy", {31'd0, busy}, 1);
        wait_idle("s1_idle");
        chk("s1_idle_sample", {8'd0, sample}, 0);
        cyc(2);
        chk("s1_addr_count", alog.size(), 4);
        for (int k = 0; k < 4 && k < alog.size(); k++)
            chk("s1_addr_seq", {18'd0, alog[k]}, k);
        chk("s1_done_once", done_seen, 1);

        // Backpressure in the first HOLD.
        write_ready = 1'b0;
        push_hit(4); done_exp++;
        trigger = 1'b1; cyc(1); trigger = 1'b0;
        cyc(2);
        for (int i = 0; i < 10; i++) begin
            chk("s2_stall_write", {31'd0, write}, 0);
            chk("s2_stall_sample", {8'd0, sample}, 32'h000100);
            cyc(1);
        end
        write_ready = 1'b1; #1;
        chk("s2_release_write", {31'd0, write}, 1);
        wait_idle("s2_idle");

        // Retrigger during HOLD of idx=2.
        exp_q.push_back(24'h000100); exp_q.push_back(24'h000200);
        push_hit(4); done_exp++;
        trigger = 1'b1; cyc(1); trigger = 1'b0;
        cyc(8);
        chk("s3_addr2", {18'd0, rom_addr}, 2);
        trigger = 1'b1; #1;
        chk("s3_no_write", {31'd0, write}, 0);
        cyc(1); trigger = 1'b0;
        chk("s3_restart_addr", {18'd0, rom_addr}, 0);
        wait_idle("s3_idle");

        // Enable dropped at idx=1, then trigger while disarmed.
        exp_q.push_back(24'h000100);
        trigger = 1'b1; cyc(1); trigger = 1'b0;
        cyc(3);
        chk("s4_addr1", {18'd0, rom_addr}, 1);
        cyc(1); enable = 1'b0;
        cyc(1);
        chk("s4_abort_busy", {31'd0, busy}, 0);
        chk("s4_abort_sample", {8'd0, sample}, 0);
        trigger = 1'b1; cyc(1); trigger = 1'b0;
        chk("s4_disarmed_busy", {31'd0, busy}, 0);
        cyc(3);
        chk("s4_disarmed_addr", {18'd0, rom_addr}, 0);
        enable = 1'b1;

        // Reset while in FETCH.
        trigger = 1'b1; cyc(1); trigger = 1'b0;
        chk("s5_fetch_busy", {31'd0, busy}, 1);
        reset = 1'b1; cyc(1);
        chk("s5_rst_busy", {31'd0, busy}, 0);
        chk("s5_rst_addr", {18'd0, rom_addr}, 0);
        chk("s5_rst_sample", {8'd0, sample}, 0);
        chk("s5_rst_write", {31'd0, write}, 0);
        reset = 1'b0; cyc(1);

        // Retrigger coincident with the final transfer: restart wins, no done.
        push_hit(3); push_hit(4); done_exp++;
        trigger = 1'b1; cyc(1); trigger = 1'b0;
        cyc(11);
        chk("s6_addr3", {18'd0, rom_addr}, 3);
        trigger = 1'b1; #1;
        chk("s6_no_write", {31'd0, write}, 0);
        cyc(1); trigger = 1'b0;
        chk("s6_restart_addr", {18'd0, rom_addr}, 0);
        chk("s6_no_done", {31'd0, done}, 0);
        wait_idle("s6_idle");

        cyc(3);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_count", done_seen, done_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
